// File: rtl/p2n_arb_pkg.sv
// Shared definitions for the p2n packet arbiter: response opcodes, body lengths and FSM states.
package p2n_arb_pkg;

    localparam logic [2:0] OP_RD_RESP = 3'b011;
    localparam logic [2:0] OP_WR_RESP = 3'b100;
    localparam logic [2:0] OP_MSG     = 3'b101;

    localparam logic [7:0] WR_RESP_BODY = 8'd4;
    localparam logic [7:0] MSG_BODY     = 8'd5;

    typedef enum logic [1:0] {IDLE, BODY, GAP} arb_state_e;

    // Bytes following the header; 0 marks an illegal opcode.
    function automatic logic [7:0] body_len(input logic [7:0] hdr);
        case (hdr[2:0])
            OP_RD_RESP: body_len = 8'd1 + (8'd1 << hdr[5:3]);
            OP_WR_RESP: body_len = WR_RESP_BODY;
            OP_MSG:     body_len = MSG_BODY;
            default:    body_len = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: the first requester after 'last' (mod 4) wins.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [3:0] onehot_o,
    output logic       any_o
);

    // Scan from lowest to highest priority so the closest requester overwrites.
    always_comb begin
        onehot_o = 4'b0000;
        for (int i = 4; i >= 1; i--) begin
            if (req_i[2'(last_i + 2'(i))]) begin
                onehot_o = 4'b0001 << 2'(last_i + 2'(i));
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/p2n_pkt_arb.sv
// Packet-aware round-robin scheduler sharing the NOC return path between four response FIFOs.
module p2n_pkt_arb #(
    parameter int unsigned NPORT    = 4,
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NPORT-1:0]   port_vld,
    input  logic [NPORT-1:0]   port_ctl,
    input  logic [8*NPORT-1:0] port_data,
    output logic [NPORT-1:0]   port_pop,
    output logic               noc_from_dev_ctl,
    output logic [7:0]         noc_from_dev_data,
    output logic [NPORT-1:0]   grant,
    output logic               busy,
    output logic               err_drop,
    output logic               err_underrun
);

    import p2n_arb_pkg::*;

    localparam logic [3:0] GAP_LOAD = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    arb_state_e       state_q;
    logic [1:0]       rr_last_q;
    logic [7:0]       cnt_q;
    logic [3:0]       gap_q;
    logic [NPORT-1:0] grant_q;
    logic             out_ctl_q;
    logic [7:0]       out_data_q;
    logic             err_drop_q;
    logic             err_underrun_q;

    logic [3:0] pick_oh;
    logic       pick_any;
    logic [1:0] pick_idx;
    logic [1:0] own_idx;
    logic       pick_ctl;
    logic       own_ctl;
    logic [7:0] pick_data;
    logic [7:0] own_data;
    logic [7:0] pick_len;

    function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
        case (oh)
            4'b0010: oh_to_idx = 2'd1;
            4'b0100: oh_to_idx = 2'd2;
            4'b1000: oh_to_idx = 2'd3;
            default: oh_to_idx = 2'd0;
        endcase
    endfunction

    rr_pick4 u_pick (
        .req_i    (port_vld),
        .last_i   (rr_last_q),
        .onehot_o (pick_oh),
        .any_o    (pick_any)
    );

    always_comb begin
        pick_idx  = oh_to_idx(pick_oh);
        own_idx   = oh_to_idx(grant_q);
        pick_ctl  = port_ctl[pick_idx];
        pick_data = port_data[{pick_idx, 3'b000} +: 8];
        own_ctl   = port_ctl[own_idx];
        own_data  = port_data[{own_idx, 3'b000} +: 8];
        pick_len  = body_len(pick_data);
        port_pop  = '0;
        // No pops while held in reset so FIFO contents survive untouched.
        if (rst_n) begin
            unique case (state_q)
                IDLE:    if (pick_any) port_pop = pick_oh;
                BODY:    port_pop = grant_q & port_vld;
                default: port_pop = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_last_q      <= 2'd3;
            cnt_q          <= 8'd0;
            gap_q          <= 4'd0;
            grant_q        <= '0;
            out_ctl_q      <= 1'b1;
            out_data_q     <= 8'h00;
            err_drop_q     <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            out_ctl_q  <= 1'b1;
            out_data_q <= 8'h00;
            err_drop_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_any && pick_ctl && pick_data != 8'h00 && pick_len != 8'd0) begin
                        out_ctl_q  <= 1'b1;
                        out_data_q <= pick_data;
                        grant_q    <= pick_oh;
                        rr_last_q  <= pick_idx;
                        cnt_q      <= pick_len;
                        state_q    <= BODY;
                    end else if (pick_any && !(pick_ctl && pick_data == 8'h00)) begin
                        // Stray body byte or illegal opcode; idle tokens fall through silently.
                        err_drop_q <= 1'b1;
                        rr_last_q  <= pick_idx;
                    end
                end
                BODY: begin
                    if (port_vld[own_idx]) begin
                        out_ctl_q  <= own_ctl;
                        out_data_q <= own_data;
                        cnt_q      <= cnt_q - 8'd1;
                        if (own_ctl) err_drop_q <= 1'b1;
                        if (cnt_q == 8'd1) begin
                            grant_q <= '0;
                            if (IDLE_GAP > 0) begin
                                state_q <= GAP;
                                gap_q   <= GAP_LOAD;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end else begin
                        err_underrun_q <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == 4'd0) state_q <= IDLE;
                    else               gap_q   <= gap_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign noc_from_dev_ctl  = out_ctl_q;
    assign noc_from_dev_data = out_data_q;
    assign grant             = grant_q;
    assign busy              = (state_q != IDLE);
    assign err_drop          = err_drop_q;
    assign err_underrun      = err_underrun_q;

endmodule

// File: doc/p2n_pkt_arb.md
Name: p2n_pkt_arb

Overview:
- Packet-aware round-robin scheduler that shares the single NOC return path (noc_from_dev_ctl/noc_from_dev_data) between four perm response FIFOs.
- Sits between the four p2n response FIFOs and the switch's NOC output.
- Grants one FIFO per packet, decodes the header to learn the packet length, and pops exactly that many bytes before re-arbitrating.
- Registers the output byte and flags framing faults.

Parameters:
- NPORT, 4, number of requesting FIFOs (arbitration logic written for 4; other values unsupported).
- IDLE_GAP, 0, idle cycles (ctl=1, data=0) forced between consecutive packets; range 0-15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- port_vld  in  4  FIFO k non-empty; head word valid (FIFO is first-word-fall-through).
- port_ctl  in  4  ctl bit of head word of FIFO k.
- port_data  in  32  head data byte of FIFO k, at bits [8k+7:8k].
- port_pop  out  4  combinational read strobe, at most one bit high.
- noc_from_dev_ctl  out  1  registered ctl to NOC.
- noc_from_dev_data  out  8  registered data to NOC.
- grant  out  4  one-hot owner of the current packet; 0 when idle.
- busy  out  1  state != IDLE.
- err_drop  out  1  one-cycle pulse: a malformed head word was discarded.
- err_underrun  out  1  sticky: granted FIFO went empty mid-packet; cleared only by reset.

Behaviour:
- Reset values: noc_from_dev_ctl=1, noc_from_dev_data=0, grant=0, busy=0, err_drop=0, err_underrun=0, state=IDLE, rr_last=3 (port 0 has first priority), cnt=0.
- Header test: valid header at port k = port_vld[k] & port_ctl[k] & (byte != 0).
- Header opcode hdr[2:0] sets the body length (bytes following the header, all ctl=0):
  - 3'b011 READ_RESP: 1 + (1 << hdr[5:3]).
  - 3'b100 WRITE_RESP: 4.
  - 3'b101 MESSAGE: 5.
  - cnt is 8 bits; maximum value is 129.
- Output register: each edge loads the popped word {ctl, data}; loads {1, 8'h00} when nothing is popped.
- FSM states: IDLE, BODY, GAP.
- IDLE:
  - Search from rr_last+1 upward, modulo 4, for the first port with port_vld=1. Only that port is evaluated.
  - Selected head is a valid header with a legal opcode: port_pop[k]=1; next edge loads the output with the header, grant=onehot(k), rr_last=k, cnt=body length, state=BODY.
  - Selected head has ctl=0, or ctl=1 with an illegal opcode: pop it and discard it, output stays idle, err_drop pulses next cycle, rr_last=k, state stays IDLE.
  - Selected head is ctl=1 with data=0 (idle token): pop and discard silently, no error, rr_last unchanged.
- BODY:
  - port_pop[k]=port_vld[k].
  - Each pop decrements cnt and forwards the word.
  - A popped word with ctl=1 is still forwarded, and err_drop pulses.
  - port_vld[k]=0: no pop, output idle, cnt holds, err_underrun set.
  - Pop with cnt==1: grant=0 and state goes to GAP (IDLE_GAP>0) or IDLE (IDLE_GAP=0).
- GAP: no pops; output idle; stay IDLE_GAP cycles, then go to IDLE.
- Latency: header popped in cycle T appears on the NOC at T+1.
- Back-to-back packets with IDLE_GAP=0: the last body byte is at T' and the next header at T'+1; no bubble.
- A packet is never interleaved with another, and never pre-empted.
- Ports that become valid mid-packet wait. RR fairness is per packet, not per byte.
- Async reset mid-packet: immediate return to reset values. Partially sent packet is abandoned; popped bytes are lost; unpopped FIFO contents are untouched.

Decomposition:
- Shared package p2n_arb_pkg holds:
  - opcode constants OP_RD_RESP=3'b011, OP_WR_RESP=3'b100, OP_MSG=3'b101;
  - WR_RESP_BODY=4, MSG_BODY=5;
  - state enum {IDLE, BODY, GAP};
  - function body_len(hdr) returning 8 bits.
- One sub-module, rr_pick4: combinational rotate-priority encoder (req[3:0], last[1:0] -> onehot[3:0], any).

Test Plan:
- Reset, then port 1 holds WRITE_RESP header 8'h84 plus 4 body bytes -> NOC shows {1,84} at T+1, then 4 ctl=0 bytes; 5 pops on port_pop[1]; grant=0010 throughout, then 0.
- All four ports hold MESSAGE packets (hdr 8'h85) at reset -> served in order 0,1,2,3; each is 6 bytes; total 24 contiguous cycles with IDLE_GAP=0.
- READ_RESP hdr 8'h1B (Dlen field 3) -> body length 9, total 10 bytes; then port 0 re-requests while port 2 waits -> port 2 is served before port 0.
- Port 3 goes empty after 2 body bytes for 3 cycles -> 3 idle words inserted, err_underrun=1, packet completes with correct byte count after refill.
- Port 0 head is ctl=0 byte 8'h55 in IDLE -> popped, discarded, err_drop pulse, NOC stays idle; opcode 3'b111 header behaves the same.
- IDLE_GAP=2: two queued packets -> exactly 2 idle cycles between them. rst_n pulsed mid-body -> outputs immediately back to 1/00/0, remaining bytes left in the FIFO.
